// File: rtl/div_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_arbiter_if
// Bundles every signal of div_arbiter other than clk/reset: the two requester
// handshakes, the shared response bus, the divider control/status pins and
// the completed-operation counter.
//
// Modports
//   slave  : arbiter view (takes requests and divider status, drives
//            ready/response/divider-control/op_count)
//   master : environment view (requesters plus divider), opposite directions
//
// Signals
//   req0_valid/req1_valid     requester N holds an operation pending
//   req0_a/req0_b/req1_a/req1_b  dividend/divisor of requester N
//   req0_ready/req1_ready     one-cycle accept pulse to requester N
//   rsp0_valid/rsp1_valid     one-cycle result pulse to requester N
//   rsp_q/rsp_r/rsp_dz        shared quotient/remainder/divide-by-zero flag
//   div_start                 one-cycle start pulse to the shared divider
//   div_a/div_b               operands held for the divider
//   div_busy/div_done/div_zero, div_q/div_r  divider status and results
//   op_count                  completed operations, wraps 255 -> 0
// -----------------------------------------------------------------------------
interface div_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_ready;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_dz;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic             div_done;
    logic             div_zero;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [7:0]       op_count;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  div_busy, div_done, div_zero, div_q, div_r,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_q, rsp_r, rsp_dz, div_start, div_a, div_b, op_count
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output div_busy, div_done, div_zero, div_q, div_r,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_q, rsp_r, rsp_dz, div_start, div_a, div_b, op_count
    );
endinterface

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one multi-cycle divider between two requesters. A round-robin pointer
// breaks ties; exactly one operation is in flight at a time
// (IDLE -> ISSUE -> WAIT -> RESP). Every output is a register.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-low
//   bus    : div_arbiter_if.slave (requesters, responses, divider, op_count)
//
// Parameters
//   WIDTH  : operand/quotient/remainder width
//   ZQ_VAL : quotient returned on a bypassed divide-by-zero
//
// Optional feature
//   DIV_ZERO_BYPASS_EN : when defined, a zero divisor skips the divider and
//                        answers q=ZQ_VAL, r=dividend, dz=1 directly.
//                        When undefined, a zero divisor goes to the divider
//                        like any other operation.
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] ZQ_VAL = {WIDTH{1'b1}}
) (
    input logic          clk,
    input logic          reset,
    div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_gnt_id;
    logic             r_req0_ready;
    logic             r_req1_ready;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp_q;
    logic [WIDTH-1:0] r_rsp_r;
    logic             r_rsp_dz;
    logic             r_div_start;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [7:0]       r_op_count;

    logic             w_any_req;
    logic             w_gnt_id;

    // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_any_req = bus.req0_valid | bus.req1_valid;
        w_gnt_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt_id = r_rr_ptr;
        end else if (bus.req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_gnt_id     <= 1'b0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_q      <= '0;
            r_rsp_r      <= '0;
            r_rsp_dz     <= 1'b0;
            r_div_start  <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_op_count   <= 8'd0;
        end else begin
            // Pulse outputs default low; the state that owns them raises them
            // for exactly one cycle.
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_div_start  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_id     <= w_gnt_id;
                        // Pointer always moves to the loser, even uncontended.
                        r_rr_ptr     <= ~w_gnt_id;
                        r_req0_ready <= ~w_gnt_id;
                        r_req1_ready <= w_gnt_id;
                        r_div_a      <= w_gnt_id ? bus.req1_a : bus.req0_a;
                        r_div_b      <= w_gnt_id ? bus.req1_b : bus.req0_b;
                        r_state      <= ISSUE;
                    end
                end

                ISSUE: begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (r_div_b == '0) begin
                        r_rsp_q  <= ZQ_VAL;
                        r_rsp_r  <= r_div_a;
                        r_rsp_dz <= 1'b1;
                        r_state  <= RESP;
                    end else if (!bus.div_busy) begin
                        r_div_start <= 1'b1;
                        r_state     <= WAIT;
                    end
`else
                    if (!bus.div_busy) begin
                        r_div_start <= 1'b1;
                        r_state     <= WAIT;
                    end
`endif
                end

                WAIT: begin
                    if (bus.div_done) begin
                        r_rsp_q  <= bus.div_q;
                        r_rsp_r  <= bus.div_r;
                        r_rsp_dz <= bus.div_zero;
                        r_state  <= RESP;
                    end
                end

                RESP: begin
                    r_rsp0_valid <= ~r_gnt_id;
                    r_rsp1_valid <= r_gnt_id;
                    r_op_count   <= r_op_count + 8'd1;
                    r_state      <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = r_req0_ready;
    assign bus.req1_ready = r_req1_ready;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_q      = r_rsp_q;
    assign bus.rsp_r      = r_rsp_r;
    assign bus.rsp_dz     = r_rsp_dz;
    assign bus.div_start  = r_div_start;
    assign bus.div_a      = r_div_a;
    assign bus.div_b      = r_div_b;
    assign bus.op_count   = r_op_count;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/quotient/remainder width.
REQ-002 Parameter: ZQ_VAL, {WIDTH{1'b1}}, quotient returned on bypassed divide-by-zero.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0_valid / req1_valid  in  1  requester N holds an operation pending.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  WIDTH  dividend, divisor of requester N.
REQ-007 req0_ready / req1_ready  out  1  one-cycle accept pulse to requester N.
REQ-008 rsp0_valid / rsp1_valid  out  1  one-cycle result pulse to requester N.
REQ-009 rsp_q, rsp_r  out  WIDTH  quotient, remainder (shared, valid with rspN_valid).
REQ-010 rsp_dz  out  1  divide-by-zero flag (shared, valid with rspN_valid).
REQ-011 div_start  out  1  one-cycle start pulse to the shared divider.
REQ-012 div_a, div_b  out  WIDTH  operands to the divider, held stable from ISSUE until result capture.
REQ-013 div_busy, div_done, div_zero  in  1  divider status.
REQ-014 div_q, div_r  in  WIDTH  divider results.
REQ-015 op_count  out  8  completed operations, wraps 255->0.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one operation in flight at any time.
REQ-017 IDLE: if exactly one reqN_valid, grant N; if both, grant the requester indicated by rr_ptr; if none, stay.
REQ-018 On grant: pulse reqN_ready for that same cycle, latch a/b and grant id, then go to ISSUE. The requester drops valid or presents a new operation after seeing ready.
REQ-019 rr_ptr toggles to the non-granted requester on every grant, whether or not the other requester was contending.
REQ-020 ISSUE: while div_busy=1, hold; when div_busy=0, pulse div_start for 1 cycle, then go to WAIT.
REQ-021 WAIT: on the first cycle with div_done=1, capture div_q, div_r, div_zero into rsp registers, then go to RESP.
REQ-022 RESP: pulse rspN_valid only for the granted id for 1 cycle, increment op_count, then go to IDLE; no grant occurs in RESP.
REQ-023 rsp_q/rsp_r/rsp_dz hold their last captured value until the next capture.
REQ-024 Minimum latency from req_ready to rsp_valid is divider latency + 3 cycles; back-to-back throughput is 1 operation per (divider latency + 4) cycles.
REQ-025 A requester deasserting valid before grant is never granted; requests are not queued.
REQ-026 Outputs div_a/div_b equal the latched operands from ISSUE through WAIT.

Reset
REQ-027 reset=0 forces at once: state IDLE, rr_ptr=0, all ready/valid/start outputs 0, rsp_q/rsp_r/rsp_dz=0, div_a/div_b=0, op_count=0.
REQ-028 Reset during ISSUE/WAIT/RESP abandons the operation; no rsp pulse is emitted afterwards; the divider is reset by the same reset net.

Configuration
REQ-029 Macro DIV_ZERO_BYPASS_EN defined: in ISSUE, latched b==0 skips the divider (no div_start) and goes straight to RESP with rsp_q=ZQ_VAL, rsp_r=latched a, rsp_dz=1.
REQ-030 Macro DIV_ZERO_BYPASS_EN undefined: b==0 is issued to the divider like any operation; rsp_dz takes div_zero, and rsp_q/rsp_r take div_q/div_r.

Verification
REQ-031 req0 only, 15/3 -> one req0_ready, one div_start, rsp0_valid with q=5 r=0 dz=0, rsp1_valid never, op_count=1.
REQ-032 req0 and req1 valid in the same cycle after reset (req0 17/5, req1 255/10) -> req0 granted first (q=3 r=2), then req1 (q=25 r=5), op_count=2.
REQ-033 Both requesters held valid continuously for 4 operations -> grants alternate 0,1,0,1; exactly one div_start per grant.
REQ-034 100/0 with DIV_ZERO_BYPASS_EN -> no div_start, rsp with q=255 r=100 dz=1 within 3 cycles of ready; without the macro -> div_start issued, dz=1 taken from div_zero.
REQ-035 div_busy held 1 for 10 cycles during ISSUE -> div_start delayed until div_busy=0, then a single pulse.
REQ-036 reset pulled low in WAIT during 20/4 -> all outputs return to reset values immediately, no rsp pulse, and the next request completes normally with q=5 r=0.
